// File: rtl/add4_accumulator.sv
// rtl/add4_accumulator.sv - sums COUNT 5-bit adder results per frame behind valid/ready handshakes.
// Optional macro SATURATE_EN: clamp acc to all-ones on overflow instead of wrapping.
module add4_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_next_acc;
  logic             w_last;

  assign w_sum  = {1'b0, r_acc} + {{(ACC_W-4){1'b0}}, cout, sum};
  assign w_last = (r_cnt == CNT_W'(COUNT - 1));

`ifdef SATURATE_EN
  // Once clamped, any further nonzero sample overflows again, so acc stays all-ones.
  assign w_next_acc = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_next_acc = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            r_acc <= w_next_acc;
            r_ovf <= r_ovf | w_sum[ACC_W];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign acc       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_add4_accumulator.sv
// tb/tb_add4_accumulator.sv - directed self-checking bench for add4_accumulator.
module tb_add4_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] sum = 4'd0;
  logic       cout = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, ovf;
  logic [7:0] acc;
  logic       in_ready6, out_valid6, ovf6;
  logic [5:0] acc6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  add4_accumulator #(.COUNT(4), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .cout(cout), .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .ovf(ovf)
  );

  add4_accumulator #(.COUNT(4), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
    .sum(sum), .cout(cout), .out_valid(out_valid6), .out_ready(out_ready), .acc(acc6), .ovf(ovf6)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s);
    in_valid = v;
    {cout, sum} = s;
  endtask

  task automatic feed_frame(input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] d);
    drive(1'b1, a); tick;
    drive(1'b1, b); tick;
    drive(1'b1, c); tick;
    drive(1'b1, d); tick;
    drive(1'b0, 5'd0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (acc !== 8'd0) begin n_errors++; $display("FAIL reset_acc: got %0d expected 0", acc); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame;
    out_ready = 1'b1;
    drive(1'b1, 5'd5); tick;
    n_checks++; if (acc !== 8'd5) begin n_errors++; $display("FAIL basic_first_acc: got %0d expected 5", acc); end
    drive(1'b1, 5'd8);  tick;
    drive(1'b1, 5'd14); tick;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    drive(1'b1, 5'd15); tick;
    drive(1'b0, 5'd0);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (acc !== 8'd42) begin n_errors++; $display("FAIL basic_acc: got %0d expected 42", acc); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL basic_in_ready_hold: got %b expected 0", in_ready); end
    tick;
    n_checks++; if (acc !== 8'd0) begin n_errors++; $display("FAIL basic_acc_cleared: got %0d expected 0", acc); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready_back: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_out_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    feed_frame(5'd5, 5'd8, 5'd14, 5'd15);
    drive(1'b1, 5'd3);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (acc !== 8'd42) begin n_errors++; $display("FAIL bp_acc[%0d]: got %0d expected 42", i, acc); end
      n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick;
    end
    drive(1'b0, 5'd0);
    out_ready = 1'b1;
    tick;
    n_checks++; if (acc !== 8'd0) begin n_errors++; $display("FAIL bp_release_acc: got %0d expected 0", acc); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_overflow;
    logic [5:0] exp3, exp4;
`ifdef SATURATE_EN
    exp3 = 6'd63; exp4 = 6'd63;
`else
    exp3 = 6'd29; exp4 = 6'd60;
`endif
    out_ready = 1'b0;
    drive(1'b1, 5'd31); tick;
    drive(1'b1, 5'd31); tick;
    n_checks++; if (acc6 !== 6'd62) begin n_errors++; $display("FAIL ovf_acc6_two: got %0d expected 62", acc6); end
    n_checks++; if (ovf6 !== 1'b0) begin n_errors++; $display("FAIL ovf_flag6_two: got %b expected 0", ovf6); end
    drive(1'b1, 5'd31); tick;
    n_checks++; if (acc6 !== exp3) begin n_errors++; $display("FAIL ovf_acc6_three: got %0d expected %0d", acc6, exp3); end
    n_checks++; if (ovf6 !== 1'b1) begin n_errors++; $display("FAIL ovf_flag6_three: got %b expected 1", ovf6); end
    drive(1'b1, 5'd31); tick;
    drive(1'b0, 5'd0);
    n_checks++; if (acc6 !== exp4) begin n_errors++; $display("FAIL ovf_acc6_final: got %0d expected %0d", acc6, exp4); end
    n_checks++; if (ovf6 !== 1'b1) begin n_errors++; $display("FAIL ovf_flag6_final: got %b expected 1", ovf6); end
    n_checks++; if (out_valid6 !== 1'b1) begin n_errors++; $display("FAIL ovf_valid6: got %b expected 1", out_valid6); end
    n_checks++; if (acc !== 8'd124) begin n_errors++; $display("FAIL ovf_acc8: got %0d expected 124", acc); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_flag8: got %b expected 0", ovf); end
    out_ready = 1'b1;
    tick;
    n_checks++; if (ovf6 !== 1'b0) begin n_errors++; $display("FAIL ovf_flag6_cleared: got %b expected 0", ovf6); end
    n_checks++; if (acc6 !== 6'd0) begin n_errors++; $display("FAIL ovf_acc6_cleared: got %0d expected 0", acc6); end
  endtask

  task automatic test_clear;
    out_ready = 1'b0;
    drive(1'b1, 5'd9); tick;
    drive(1'b1, 5'd9); tick;
    n_checks++; if (acc !== 8'd18) begin n_errors++; $display("FAIL clr_partial: got %0d expected 18", acc); end
    drive(1'b1, 5'd7);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n_checks++; if (acc !== 8'd0) begin n_errors++; $display("FAIL clr_acc: got %0d expected 0", acc); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL clr_in_ready: got %b expected 1", in_ready); end
    feed_frame(5'd1, 5'd1, 5'd1, 5'd1);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL clr_next_valid: got %b expected 1", out_valid); end
    n_checks++; if (acc !== 8'd4) begin n_errors++; $display("FAIL clr_next_acc: got %0d expected 4", acc); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL clr_next_ovf: got %b expected 0", ovf); end
    out_ready = 1'b1;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL clr_hold_valid: got %b expected 0", out_valid); end
    n_checks++; if (acc !== 8'd0) begin n_errors++; $display("FAIL clr_hold_acc: got %0d expected 0", acc); end
  endtask

  task automatic test_gapped;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i)); tick;
      drive(1'b0, 5'd31); tick;
      if (i < 4) begin
        n_checks++; if (acc !== 8'(i * (i + 1) / 2)) begin n_errors++; $display("FAIL gap_acc[%0d]: got %0d expected %0d", i, acc, i * (i + 1) / 2); end
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL gap_handshake_done: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i)); tick;
      drive(1'b0, 5'd31);
      if (i < 4) tick;
    end
    n_checks++; if (acc !== 8'd10) begin n_errors++; $display("FAIL gap_acc_final: got %0d expected 10", acc); end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_midframe_reset;
    out_ready = 1'b1;
    drive(1'b1, 5'd1); tick;
    drive(1'b1, 5'd2); tick;
    drive(1'b1, 5'd3); tick;
    drive(1'b0, 5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (acc !== 8'd0) begin n_errors++; $display("FAIL mrst_acc: got %0d expected 0", acc); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mrst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mrst_out_valid: got %b expected 0", out_valid); end
    tick;
    rst_n = 1'b1;
    out_ready = 1'b0;
    feed_frame(5'd5, 5'd8, 5'd14, 5'd15);
    n_checks++; if (acc !== 8'd42) begin n_errors++; $display("FAIL mrst_next_acc: got %0d expected 42", acc); end
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mrst_next_valid: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    tick;
  endtask

  initial begin
    #2;
    test_reset;
    test_basic_frame;
    test_backpressure;
    test_overflow;
    test_clear;
    test_gapped;
    test_midframe_reset;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
